// File: rtl/inter_core_mailbox_router.sv
// Inter-core mailbox router: per-destination FIFOs, round-robin unicast
// arbitration, atomic broadcast, invalid-destination drop and counters.
module inter_core_mailbox_router #(
    parameter int NUM_HARTS = 4,
    parameter int HART_ID_W = 3,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64,
    parameter logic [HART_ID_W-1:0] BCAST_ID = '1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_HARTS-1:0]                   src_valid_i,
    output logic [NUM_HARTS-1:0]                   src_ready_o,
    input  logic [NUM_HARTS*HART_ID_W-1:0]         src_dst_i,
    input  logic [NUM_HARTS*4-1:0]                 src_opcode_i,
    input  logic [NUM_HARTS*PAYLOAD_W-1:0]         src_payload_i,
    output logic [NUM_HARTS-1:0]                   dst_valid_o,
    input  logic [NUM_HARTS-1:0]                   dst_ready_i,
    output logic [NUM_HARTS*HART_ID_W-1:0]         dst_src_o,
    output logic [NUM_HARTS*4-1:0]                 dst_opcode_o,
    output logic [NUM_HARTS*PAYLOAD_W-1:0]         dst_payload_o,
    output logic [NUM_HARTS*($clog2(DEPTH)+1)-1:0] dst_count_o,
    output logic                                   err_o,
    output logic [31:0]                            msg_count_o,
    output logic [15:0]                            drop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (2**HART_ID_W <= NUM_HARTS) begin : g_bad_id_w
        $error("HART_ID_W too narrow for NUM_HARTS plus broadcast ID");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (NUM_HARTS < 2 || NUM_HARTS > 16) begin : g_bad_harts
        $error("NUM_HARTS must be in 2..16");
    end

    typedef struct packed {
        logic [HART_ID_W-1:0] src;
        logic [3:0]           op;
        logic [PAYLOAD_W-1:0] pl;
    } msg_t;

    function automatic int rr_idx(input int base, input int off);
        return (base + off) % NUM_HARTS;
    endfunction

    msg_t                 mem_q [NUM_HARTS][DEPTH];
    msg_t                 mem_d [NUM_HARTS][DEPTH];
    logic [AW-1:0]        wr_q [NUM_HARTS];
    logic [AW-1:0]        wr_d [NUM_HARTS];
    logic [AW-1:0]        rd_q [NUM_HARTS];
    logic [AW-1:0]        rd_d [NUM_HARTS];
    logic [CW-1:0]        cnt_q [NUM_HARTS];
    logic [CW-1:0]        cnt_d [NUM_HARTS];
    logic [HART_ID_W-1:0] ptr_q [NUM_HARTS];
    logic [HART_ID_W-1:0] ptr_d [NUM_HARTS];
    logic [HART_ID_W-1:0] bptr_q, bptr_d;
    logic                 err_q, err_d;
    logic [31:0]          msg_q, msg_d;
    logic [15:0]          drop_q, drop_d;

    logic [HART_ID_W-1:0] dst_a [NUM_HARTS];
    msg_t                 in_msg [NUM_HARTS];
    logic [NUM_HARTS-1:0] is_bc, is_uni, is_inv;
    logic                 bsel_vld, bc_ok, bc_go;
    logic [HART_ID_W-1:0] bsel;
    logic [NUM_HARTS-1:0] uni_vld, uni_go;
    logic [HART_ID_W-1:0] uni_src [NUM_HARTS];
    logic [NUM_HARTS-1:0] push, pop;
    msg_t                 pmsg [NUM_HARTS];
    logic [7:0]           n_acc, n_drop;
    logic [32:0]          msg_sum;
    logic [16:0]          drop_sum;

    // Unpack source fields and classify each request
    always_comb begin
        for (int s = 0; s < NUM_HARTS; s++) begin
            dst_a[s]      = src_dst_i[s*HART_ID_W +: HART_ID_W];
            in_msg[s].src = HART_ID_W'(s);
            in_msg[s].op  = src_opcode_i[s*4 +: 4];
            in_msg[s].pl  = src_payload_i[s*PAYLOAD_W +: PAYLOAD_W];
            is_bc[s]  = src_valid_i[s] && (dst_a[s] == BCAST_ID);
            is_uni[s] = src_valid_i[s]
                        && (32'(dst_a[s]) < 32'(NUM_HARTS));
            is_inv[s] = src_valid_i[s] && !is_bc[s] && !is_uni[s];
        end
    end

    // Pick one broadcaster round-robin; it fires only if all targets have room
    always_comb begin
        bsel_vld = 1'b0;
        bsel     = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (!bsel_vld && is_bc[rr_idx(int'(bptr_q), i)]) begin
                bsel_vld = 1'b1;
                bsel     = HART_ID_W'(rr_idx(int'(bptr_q), i));
            end
        end
        bc_ok = 1'b1;
        for (int d = 0; d < NUM_HARTS; d++) begin
            if (bsel != HART_ID_W'(d) && !(cnt_q[d] < CW'(DEPTH)))
                bc_ok = 1'b0;
        end
        bc_go = bsel_vld && bc_ok;
    end

    // Per-destination round-robin unicast grant; a pending broadcast
    // reserves every target FIFO except the broadcaster's own
    always_comb begin
        for (int d = 0; d < NUM_HARTS; d++) begin
            uni_vld[d] = 1'b0;
            uni_src[d] = '0;
            for (int i = 0; i < NUM_HARTS; i++) begin
                if (!uni_vld[d]
                    && is_uni[rr_idx(int'(ptr_q[d]), i)]
                    && dst_a[rr_idx(int'(ptr_q[d]), i)]
                       == HART_ID_W'(d)) begin
                    uni_vld[d] = 1'b1;
                    uni_src[d] = HART_ID_W'(rr_idx(int'(ptr_q[d]), i));
                end
            end
            uni_go[d] = uni_vld[d]
                        && (cnt_q[d] < CW'(DEPTH))
                        && !(bsel_vld && bsel != HART_ID_W'(d));
        end
    end

    // Accept: drops always, granted unicasts, the firing broadcaster
    always_comb begin
        src_ready_o = '0;
        if (!rst_i) begin
            for (int s = 0; s < NUM_HARTS; s++) begin
                if (is_inv[s])
                    src_ready_o[s] = 1'b1;
                if (bc_go && bsel == HART_ID_W'(s))
                    src_ready_o[s] = 1'b1;
                for (int d = 0; d < NUM_HARTS; d++) begin
                    if (uni_go[d] && uni_src[d] == HART_ID_W'(s))
                        src_ready_o[s] = 1'b1;
                end
            end
        end
    end

    // Next FIFO, pointer and counter state
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        bptr_d = bptr_q;
        n_acc  = '0;
        n_drop = '0;
        for (int d = 0; d < NUM_HARTS; d++) begin
            push[d] = 1'b0;
            pmsg[d] = in_msg[0];
            for (int s = 0; s < NUM_HARTS; s++) begin
                if (uni_go[d] && uni_src[d] == HART_ID_W'(s)) begin
                    push[d]  = 1'b1;
                    pmsg[d]  = in_msg[s];
                    ptr_d[d] = HART_ID_W'((s + 1) % NUM_HARTS);
                end
                if (bc_go && bsel == HART_ID_W'(s) && d != s) begin
                    push[d] = 1'b1;
                    pmsg[d] = in_msg[s];
                end
            end
            pop[d] = (cnt_q[d] != '0) && dst_ready_i[d];
            if (push[d]) begin
                mem_d[d][wr_q[d]] = pmsg[d];
                wr_d[d] = wr_q[d] + AW'(1);
            end
            if (pop[d])
                rd_d[d] = rd_q[d] + AW'(1);
            cnt_d[d] = cnt_q[d] + CW'(push[d]) - CW'(pop[d]);
            if (uni_go[d])
                n_acc = n_acc + 8'd1;
        end
        for (int s = 0; s < NUM_HARTS; s++) begin
            if (bc_go && bsel == HART_ID_W'(s))
                bptr_d = HART_ID_W'((s + 1) % NUM_HARTS);
            if (is_inv[s])
                n_drop = n_drop + 8'd1;
        end
        if (bc_go)
            n_acc = n_acc + 8'd1;
        msg_sum  = {1'b0, msg_q} + 33'(n_acc);
        msg_d    = msg_sum[32] ? '1 : msg_sum[31:0];
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
        err_d    = |is_inv;
    end

    // State registers; reset empties FIFOs and clears pointers/counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int d = 0; d < NUM_HARTS; d++) begin
                wr_q[d]  <= '0;
                rd_q[d]  <= '0;
                cnt_q[d] <= '0;
                ptr_q[d] <= '0;
            end
            bptr_q <= '0;
            err_q  <= 1'b0;
            msg_q  <= '0;
            drop_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            bptr_q <= bptr_d;
            err_q  <= err_d;
            msg_q  <= msg_d;
            drop_q <= drop_d;
        end
    end

    // Present FIFO heads and occupancy
    always_comb begin
        dst_valid_o   = '0;
        dst_src_o     = '0;
        dst_opcode_o  = '0;
        dst_payload_o = '0;
        dst_count_o   = '0;
        for (int d = 0; d < NUM_HARTS; d++) begin
            dst_valid_o[d] = cnt_q[d] != '0;
            dst_src_o[d*HART_ID_W +: HART_ID_W] = mem_q[d][rd_q[d]].src;
            dst_opcode_o[d*4 +: 4] = mem_q[d][rd_q[d]].op;
            dst_payload_o[d*PAYLOAD_W +: PAYLOAD_W] = mem_q[d][rd_q[d]].pl;
            dst_count_o[d*CW +: CW] = cnt_q[d];
        end
    end

    assign err_o        = err_q;
    assign msg_count_o  = msg_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_inter_core_mailbox_router.sv
// Bench for inter_core_mailbox_router: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_inter_core_mailbox_router;
    localparam int NH = 4;
    localparam int IW = 3;
    localparam int D  = 4;
    localparam int PW = 64;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NH-1:0]    s_val;
    logic [IW-1:0]    s_dst [NH];
    logic [3:0]       s_op [NH];
    logic [PW-1:0]    s_pl [NH];
    logic [NH-1:0]    dst_ready;

    logic [NH*IW-1:0] src_dst;
    logic [NH*4-1:0]  src_op;
    logic [NH*PW-1:0] src_pl;
    logic [NH-1:0]    src_ready;
    logic [NH-1:0]    dst_valid;
    logic [NH*IW-1:0] dst_src;
    logic [NH*4-1:0]  dst_op;
    logic [NH*PW-1:0] dst_pl;
    logic [NH*CW-1:0] dst_count;
    logic             err;
    logic [31:0]      msg_count;
    logic [15:0]      drop_count;

    always_comb begin
        src_dst = '0;
        src_op  = '0;
        src_pl  = '0;
        for (int s = 0; s < NH; s++) begin
            src_dst[s*IW +: IW] = s_dst[s];
            src_op[s*4 +: 4]    = s_op[s];
            src_pl[s*PW +: PW]  = s_pl[s];
        end
    end

    inter_core_mailbox_router #(
        .NUM_HARTS(NH), .HART_ID_W(IW), .DEPTH(D), .PAYLOAD_W(PW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .src_valid_i(s_val), .src_ready_o(src_ready),
        .src_dst_i(src_dst), .src_opcode_i(src_op),
        .src_payload_i(src_pl),
        .dst_valid_o(dst_valid), .dst_ready_i(dst_ready),
        .dst_src_o(dst_src), .dst_opcode_o(dst_op),
        .dst_payload_o(dst_pl), .dst_count_o(dst_count),
        .err_o(err), .msg_count_o(msg_count),
        .drop_count_o(drop_count)
    );

    typedef struct {
        int          src;
        int          op;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t        mq [NH][$];
    int          m_ptr [NH];
    int          m_bptr;
    bit          m_err;
    longint      m_msg, m_drop;
    logic [NH-1:0] e_rdy;
    int          g_uni [NH];
    int          g_bc;
    int          n_inv;

    int total = 0;
    int bad   = 0;
    logic [NH-1:0] last_rdy = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input int s);
        ent_t e;
        e.src = s;
        e.op  = int'(s_op[s]);
        e.pl  = s_pl[s];
        return e;
    endfunction

    // Decide this cycle's acceptances from the arbitration rules
    task automatic decide();
        int bsel;
        int g;
        int s;
        bit ok;
        e_rdy = '0;
        g_bc  = -1;
        n_inv = 0;
        for (int d = 0; d < NH; d++) g_uni[d] = -1;
        if (rst) return;
        bsel = -1;
        for (int i = 0; i < NH; i++) begin
            s = (m_bptr + i) % NH;
            if (bsel < 0 && s_val[s] && s_dst[s] == 3'd7) bsel = s;
        end
        if (bsel >= 0) begin
            ok = 1;
            for (int d = 0; d < NH; d++)
                if (d != bsel && mq[d].size() >= D) ok = 0;
            if (ok) begin
                g_bc = bsel;
                e_rdy[bsel] = 1'b1;
            end
        end
        for (int d = 0; d < NH; d++) begin
            g = -1;
            for (int i = 0; i < NH; i++) begin
                s = (m_ptr[d] + i) % NH;
                if (g < 0 && s_val[s] && int'(s_dst[s]) == d) g = s;
            end
            if (g >= 0 && !(bsel >= 0 && d != bsel)
                && mq[d].size() < D) begin
                g_uni[d] = g;
                e_rdy[g] = 1'b1;
            end
        end
        for (int k = 0; k < NH; k++) begin
            if (s_val[k] && int'(s_dst[k]) >= NH && s_dst[k] != 3'd7) begin
                n_inv++;
                e_rdy[k] = 1'b1;
            end
        end
    endtask

    // Advance the model across the coming clock edge
    task automatic step();
        int nacc;
        if (rst) begin
            for (int d = 0; d < NH; d++) begin
                mq[d].delete();
                m_ptr[d] = 0;
            end
            m_bptr = 0;
            m_err  = 0;
            m_msg  = 0;
            m_drop = 0;
            return;
        end
        for (int d = 0; d < NH; d++)
            if (mq[d].size() > 0 && dst_ready[d]) void'(mq[d].pop_front());
        nacc = 0;
        for (int d = 0; d < NH; d++) begin
            if (g_uni[d] >= 0) begin
                mq[d].push_back(mk(g_uni[d]));
                m_ptr[d] = (g_uni[d] + 1) % NH;
                nacc++;
            end
        end
        if (g_bc >= 0) begin
            for (int d = 0; d < NH; d++)
                if (d != g_bc) mq[d].push_back(mk(g_bc));
            m_bptr = (g_bc + 1) % NH;
            nacc++;
        end
        m_msg  = m_msg + nacc;
        if (m_msg > 64'hFFFF_FFFF) m_msg = 64'hFFFF_FFFF;
        m_drop = m_drop + n_inv;
        if (m_drop > 65535) m_drop = 65535;
        m_err = n_inv > 0;
    endtask

    // Per-cycle comparison of every meaningful output against the model
    task automatic compare();
        decide();
        chk("src_ready", 64'(src_ready), 64'(e_rdy));
        for (int d = 0; d < NH; d++) begin
            chk($sformatf("count%0d", d),
                64'(dst_count[d*CW +: CW]), 64'(mq[d].size()));
            chk($sformatf("valid%0d", d),
                64'(dst_valid[d]), 64'(mq[d].size() > 0));
            if (mq[d].size() > 0) begin
                chk($sformatf("hsrc%0d", d),
                    64'(dst_src[d*IW +: IW]), 64'(mq[d][0].src));
                chk($sformatf("hop%0d", d),
                    64'(dst_op[d*4 +: 4]), 64'(mq[d][0].op));
                chk($sformatf("hpl%0d", d),
                    dst_pl[d*PW +: PW], mq[d][0].pl);
            end
        end
        chk("err", 64'(err), 64'(m_err));
        chk("msg_count", 64'(msg_count), m_msg);
        chk("drop_count", 64'(drop_count), m_drop);
        last_rdy = src_ready;
    endtask

    task automatic tick();
        #1;
        compare();
        step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] cnt(input int d);
        return 64'(dst_count[d*CW +: CW]);
    endfunction

    task automatic send_t1(input string tag);
        s_val = '0;
        s_val[0] = 1'b1;
        s_dst[0] = 3'd2;
        s_op[0]  = 4'd1;
        s_pl[0]  = 64'hA5;
        tick();
        chk({tag, "_rdy"}, 64'(last_rdy[0]), 64'd1);
        s_val = '0;
        #1;
        chk({tag, "_v2"}, 64'(dst_valid[2]), 64'd1);
        chk({tag, "_src"}, 64'(dst_src[2*IW +: IW]), 64'd0);
        chk({tag, "_op"}, 64'(dst_op[2*4 +: 4]), 64'd1);
        chk({tag, "_pl"}, dst_pl[2*PW +: PW], 64'hA5);
        chk({tag, "_cnt"}, cnt(2), 64'd1);
        chk({tag, "_msg"}, 64'(msg_count), 64'd1);
    endtask

    task automatic chk_reset(input string tag);
        #1;
        chk({tag, "_valid"}, 64'(dst_valid), 64'd0);
        chk({tag, "_cnt"}, 64'(dst_count), 64'd0);
        chk({tag, "_msg"}, 64'(msg_count), 64'd0);
        chk({tag, "_drop"}, 64'(drop_count), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int n;
        int r;
        int rr_exp [6];
        s_val = '0;
        dst_ready = '0;
        for (int s = 0; s < NH; s++) begin
            s_dst[s] = '0;
            s_op[s]  = '0;
            s_pl[s]  = '0;
            m_ptr[s] = 0;
        end
        m_bptr = 0;
        m_err  = 0;
        m_msg  = 0;
        m_drop = 0;

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;

        send_t1("t1");

        s_val[1] = 1'b1;
        s_dst[1] = 3'd5;
        s_op[1]  = 4'd3;
        tick();
        chk("t5_rdy", 64'(last_rdy[1]), 64'd1);
        s_val = '0;
        #1;
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_drop", 64'(drop_count), 64'd1);
        chk("t5_cnt2", cnt(2), 64'd1);
        tick();
        #1;
        chk("t5_err_off", 64'(err), 64'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        rr_exp = '{0, 1, 3, 0, 1, 3};
        dst_ready = 4'b0100;
        s_val = 4'b1011;
        for (int s = 0; s < NH; s++) s_dst[s] = 3'd2;
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < NH; s++) s_pl[s] = 64'(k * 16 + s);
            tick();
            chk($sformatf("t2_grant%0d", k), 64'(last_rdy),
                64'(1 << rr_exp[k]));
        end
        s_val = '0;
        dst_ready = '1;
        repeat (3) tick();

        dst_ready = '0;
        s_val[0] = 1'b1;
        s_dst[0] = 3'd1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            s_pl[0] = 64'(100 + n);
            tick();
            if (last_rdy[0]) n++;
        end
        chk("t3_accepted", 64'(n), 64'd4);
        #1;
        chk("t3_cnt1", cnt(1), 64'd4);
        dst_ready[1] = 1'b1;
        tick();
        chk("t3_no_pass", 64'(last_rdy[0]), 64'd0);
        tick();
        chk("t3_fifth", 64'(last_rdy[0]), 64'd1);
        s_val = '0;
        dst_ready = '1;
        repeat (6) tick();

        dst_ready = '0;
        s_val[1] = 1'b1;
        s_dst[1] = 3'd0;
        n = 0;
        for (int k = 0; k < 10 && n < 4; k++) begin
            s_pl[1] = 64'(200 + n);
            tick();
            if (last_rdy[1]) n++;
        end
        chk("t4_fill", 64'(n), 64'd4);
        s_val[1] = 1'b0;
        s_val[2] = 1'b1;
        s_dst[2] = 3'd7;
        s_pl[2]  = 64'hB0B0;
        s_val[3] = 1'b1;
        s_dst[3] = 3'd1;
        s_pl[3]  = 64'h3333;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("t4_wait%0d", k), 64'(last_rdy), 64'd0);
        end
        dst_ready[0] = 1'b1;
        tick();
        chk("t4_no_pass", 64'(last_rdy), 64'd0);
        dst_ready = '0;
        tick();
        chk("t4_bcast", 64'(last_rdy), 64'b0100);
        s_val[2] = 1'b0;
        #1;
        chk("t4_cnt0", cnt(0), 64'd4);
        chk("t4_cnt1", cnt(1), 64'd1);
        chk("t4_cnt2", cnt(2), 64'd0);
        chk("t4_cnt3", cnt(3), 64'd1);
        chk("t4_src1", 64'(dst_src[1*IW +: IW]), 64'd2);
        tick();
        chk("t4_uni_after", 64'(last_rdy), 64'b1000);
        s_val = '0;
        tick();

        s_val[0] = 1'b1;
        s_dst[0] = 3'd2;
        rst = 1'b1;
        tick();
        chk("t6_rdy_in_rst", 64'(last_rdy), 64'd0);
        rst = 1'b0;
        chk_reset("t6");
        send_t1("t6b");

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            dst_ready = NH'($urandom);
            for (int s = 0; s < NH; s++) begin
                if (!s_val[s] || last_rdy[s]) begin
                    s_val[s] = ($urandom_range(0, 9) < 6);
                    r = $urandom_range(0, 9);
                    if (r < 6)
                        s_dst[s] = IW'(r % NH);
                    else if (r < 8)
                        s_dst[s] = 3'd7;
                    else
                        s_dst[s] = IW'(4 + $urandom_range(0, 2));
                    s_op[s] = 4'($urandom);
                    s_pl[s] = {$urandom, $urandom};
                end
            end
            tick();
        end
        rst = 1'b0;
        s_val = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
